// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST response analyzer: state encoding,
// default widths and the supported read-latency range.
package bist_pkg;

  localparam int DEF_A_WIDTH = 4;
  localparam int DEF_D_WIDTH = 8;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Wide enough to count up to RD_LAT_MAX-1 drain cycles.
  localparam int DRAIN_CNT_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_PASS  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_PASS  = S_PASS,
    ST_FAIL  = S_FAIL
  } state_t;

endpackage

// File: rtl/bist_align_pipe.sv
// RD_LAT-deep delay line carrying {valid, exp_bit, addr} so the expected bit
// and address line up with the memory's returned read data.
module bist_align_pipe
  import bist_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               exp_bit,
  input  logic [A_WIDTH-1:0] addr,
  output logic               valid_out,
  output logic               exp_bit_out,
  output logic [A_WIDTH-1:0] addr_out
);

  logic [RD_LAT-1:0]  valid_q;
  logic [RD_LAT-1:0]  exp_q;
  logic [A_WIDTH-1:0] addr_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      exp_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= load;
      exp_q[0]   <= exp_bit;
      addr_q[0]  <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        exp_q[i]   <= exp_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_out   = valid_q[RD_LAT-1];
  assign exp_bit_out = exp_q[RD_LAT-1];
  assign addr_out    = addr_q[RD_LAT-1];

endmodule

// File: rtl/bist_response_analyzer.sv
// Memory BIST response analyzer: realigns expected data, compares, counts
// mismatches, captures the first failure and reports a pass/fail verdict.
// Optional fail-stop behaviour is enabled with `define BIST_FAIL_STOP_EN.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int RD_LAT  = 1,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               read_in,
  input  logic               exp_bit,
  input  logic [A_WIDTH-1:0] addr_in,
  input  logic               done_in,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [D_WIDTH-1:0] fail_data,
  output logic               halt
);

  state_t state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_q;
  logic                   drain_last;
  logic                   start_ok;
  logic                   stop_req;

  logic               pipe_valid;
  logic               pipe_exp;
  logic [A_WIDTH-1:0] pipe_addr;
  logic               miscompare;

  logic               mismatch_q;
  logic [ERR_W-1:0]   err_q;
  logic [A_WIDTH-1:0] fail_addr_q;
  logic [D_WIDTH-1:0] fail_data_q;
  logic               first_seen_q;

  bist_align_pipe #(
    .A_WIDTH (A_WIDTH),
    .RD_LAT  (RD_LAT)
  ) u_align (
    .clk         (clk),
    .rst         (rst),
    .load        (read_in && (state_q == ST_RUN)),
    .exp_bit     (exp_bit),
    .addr        (addr_in),
    .valid_out   (pipe_valid),
    .exp_bit_out (pipe_exp),
    .addr_out    (pipe_addr)
  );

  assign miscompare = pipe_valid && (rdata != {D_WIDTH{pipe_exp}});
  assign drain_last = (drain_q == DRAIN_CNT_W'(RD_LAT - 1));
  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_PASS ||
                                state_q == ST_FAIL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The last drain cycle can still hold a compare, so the verdict folds it in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: if (start) state_d = ST_RUN;
      ST_RUN:   if (done_in || stop_req) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last)
                  state_d = ((err_q != '0) || miscompare) ? ST_FAIL : ST_PASS;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        drain_q <= '0;
    else if (state_q != ST_DRAIN)   drain_q <= '0;
    else if (!drain_last)           drain_q <= drain_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q   <= 1'b0;
      err_q        <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      first_seen_q <= 1'b0;
    end else if (start_ok) begin
      mismatch_q   <= 1'b0;
      err_q        <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      mismatch_q <= miscompare;
      if (miscompare) begin
        if (err_q != {ERR_W{1'b1}}) err_q <= err_q + ERR_W'(1);
        if (!first_seen_q) begin
          fail_addr_q  <= pipe_addr;
          fail_data_q  <= rdata;
          first_seen_q <= 1'b1;
        end
      end
    end
  end

`ifdef BIST_FAIL_STOP_EN
  logic halt_q;

  assign stop_req = miscompare;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             halt_q <= 1'b0;
    else if (start_ok)   halt_q <= 1'b0;
    else if (miscompare) halt_q <= 1'b1;
  end

  assign halt = halt_q;
`else
  assign stop_req = 1'b0;
  assign halt     = 1'b0;
`endif

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer: default build, RD_LAT=1 and 3,
// ERR_W=8 and 2, driven by one shared stimulus with a latency-aware memory model.
module tb_bist_response_analyzer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       read_in;
  logic       exp_bit;
  logic [3:0] addr_in;
  logic       done_in;
  logic [7:0] rdata1;
  logic [7:0] rdata3;

  logic       busy1, pass1, fail1, mismatch1, halt1;
  logic [7:0] err1;
  logic [3:0] fa1;
  logic [7:0] fd1;

  logic       busy3, pass3, fail3, mismatch3, halt3;
  logic [7:0] err3;
  logic [3:0] fa3;
  logic [7:0] fd3;

  logic       busy_e2, pass_e2, fail_e2, mismatch_e2, halt_e2;
  logic [1:0] err_e2;
  logic [3:0] fa_e2;
  logic [7:0] fd_e2;

  logic [7:0] hist [4];
  int checks, passed;
  int cyc, mm1, mm3, mm_cyc1, rd_cyc;

  bist_response_analyzer #(.A_WIDTH(4), .D_WIDTH(8), .RD_LAT(1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .read_in(read_in), .exp_bit(exp_bit),
    .addr_in(addr_in), .done_in(done_in), .rdata(rdata1), .busy(busy1),
    .pass(pass1), .fail(fail1), .mismatch(mismatch1), .err_count(err1),
    .fail_addr(fa1), .fail_data(fd1), .halt(halt1)
  );

  bist_response_analyzer #(.A_WIDTH(4), .D_WIDTH(8), .RD_LAT(3), .ERR_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .read_in(read_in), .exp_bit(exp_bit),
    .addr_in(addr_in), .done_in(done_in), .rdata(rdata3), .busy(busy3),
    .pass(pass3), .fail(fail3), .mismatch(mismatch3), .err_count(err3),
    .fail_addr(fa3), .fail_data(fd3), .halt(halt3)
  );

  bist_response_analyzer #(.A_WIDTH(4), .D_WIDTH(8), .RD_LAT(1), .ERR_W(2)) dut_e2 (
    .clk(clk), .rst(rst), .start(start), .read_in(read_in), .exp_bit(exp_bit),
    .addr_in(addr_in), .done_in(done_in), .rdata(rdata1), .busy(busy_e2),
    .pass(pass_e2), .fail(fail_e2), .mismatch(mismatch_e2), .err_count(err_e2),
    .fail_addr(fa_e2), .fail_data(fd_e2), .halt(halt_e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // One clock per call: inputs are applied at a falling edge, the memory model
  // returns each read's data 1 and 3 calls later, outputs are sampled at the
  // next falling edge.
  task automatic drive(input bit st, input bit rd, input bit e,
                       input logic [3:0] a, input logic [7:0] flip, input bit dn);
    start   = st;
    read_in = rd;
    exp_bit = e;
    addr_in = a;
    done_in = dn;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = rd ? ({8{e}} ^ flip) : 8'h00;
    rdata1  = hist[1];
    rdata3  = hist[3];
    @(negedge clk);
    cyc++;
    if (mismatch1) begin
      mm1++;
      mm_cyc1 = cyc;
    end
    if (mismatch3) mm3++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] fault_flip(input logic [3:0] a, input bit second);
    logic [7:0] f;
    f = 8'h00;
    if (a == 4'd3)  f = second ? 8'h10 : 8'h01;
    if (a == 4'd9)  f = second ? 8'h08 : 8'h80;
    if (a == 4'd12) f = 8'hFF;
    return f;
  endfunction

  initial begin
    checks = 0; passed = 0; cyc = 0; mm1 = 0; mm3 = 0; mm_cyc1 = 0; rd_cyc = 0;
    rst = 1'b1; start = 1'b0; read_in = 1'b0; exp_bit = 1'b0; addr_in = 4'h0;
    done_in = 1'b0; rdata1 = 8'h00; rdata3 = 8'h00;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_busy", busy1, 0);
    check("rst_pass", pass1, 0);
    check("rst_fail", fail1, 0);
    check("rst_err", err1, 0);
    check("rst_halt", halt1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run: 16 reads expecting 0, then 16 expecting 1.
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    check("clean_busy_after_start", busy1, 1);
    for (int i = 0; i < 32; i++) drive(0, 1, (i >= 16), 4'(i), 8'h00, 0);
    drive(0, 0, 0, 4'h0, 8'h00, 1);
    check("clean_pass_not_early", pass1, 0);
    check("clean_busy_drain", busy1, 1);
    idle(1);
    check("clean_pass", pass1, 1);
    check("clean_busy_done", busy1, 0);
    check("clean_fail", fail1, 0);
    check("clean_err", err1, 0);
    check("clean_mm_pulses", mm1, 0);
    idle(1);
    check("clean_l3_pass_not_early", pass3, 0);
    idle(1);
    check("clean_l3_pass", pass3, 1);
    check("clean_l3_mm_pulses", mm3, 0);
    check("halt_tied_low", halt1, 0);

    // A faulty read while in PASS is not sampled.
    drive(0, 1, 0, 4'd5, 8'hFF, 0);
    idle(3);
    check("pass_read_ignored_mm", mm1, 0);
    check("pass_read_ignored_err", err1, 0);
    check("pass_held", pass1, 1);

    // Single fault: bit 2 flipped at address 5.
    mm1 = 0;
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    check("single_pass_cleared", pass1, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 4'(i), (i == 5) ? 8'h04 : 8'h00, 0);
      if (i == 5) rd_cyc = cyc;
    end
    drive(0, 0, 0, 4'h0, 8'h00, 1);
    idle(3);
    check("single_mm_pulses", mm1, 1);
    check("single_mm_latency", mm_cyc1, rd_cyc + 1);
    check("single_err", err1, 1);
    check("single_fail_addr", fa1, 5);
    check("single_fail_data", fd1, 8'h04);
    check("single_fail", fail1, 1);
    check("single_pass", pass1, 0);

    // Six faults over both passes; start mid-run must be ignored.
    mm1 = 0; mm3 = 0;
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    check("multi_err_cleared", err1, 0);
    check("multi_fail_cleared", fail1, 0);
    for (int i = 0; i < 32; i++)
      drive((i == 14), 1, (i >= 16), 4'(i), fault_flip(4'(i), (i >= 16)), (i == 31));
    idle(3);
    check("multi_err", err1, 6);
    check("multi_fail_addr", fa1, 3);
    check("multi_fail_data", fd1, 8'h01);
    check("multi_mm_pulses", mm1, 6);
    check("multi_fail", fail1, 1);
    check("multi_l3_err", err3, 6);
    check("multi_e2_saturated", err_e2, 3);
    check("multi_e2_fail", fail_e2, 1);

    // Back-to-back reads with done_in on the last one, which is faulty.
    mm3 = 0;
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 4; i++)
      drive(0, 1, 1, 4'(i), (i == 3) ? 8'h02 : 8'h00, (i == 3));
    idle(1);
    check("coinc_l1_fail", fail1, 1);
    check("coinc_l1_err", err1, 1);
    idle(1);
    check("coinc_l3_no_verdict", fail3, 0);
    check("coinc_l3_busy", busy3, 1);
    check("coinc_l3_err_pending", err3, 0);
    idle(1);
    check("coinc_l3_fail", fail3, 1);
    check("coinc_l3_err", err3, 1);
    check("coinc_l3_fail_addr", fa3, 3);
    check("coinc_l3_fail_data", fd3, 8'hFD);
    check("coinc_l3_mismatch", mismatch3, 1);
    check("coinc_l3_mm_pulses", mm3, 1);

    // Reset mid-run with a faulty read still in flight.
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    drive(0, 1, 0, 4'd2, 8'h10, 0);
    drive(0, 0, 0, 4'h0, 8'h00, 0);
    check("rstmid_err_before", err1, 1);
    drive(0, 1, 0, 4'd4, 8'h20, 0);
    rst = 1'b1;
    #1;
    check("rstmid_err", err1, 0);
    check("rstmid_fail_addr", fa1, 0);
    check("rstmid_fail_data", fd1, 0);
    check("rstmid_busy", busy1, 0);
    check("rstmid_mismatch", mismatch1, 0);
    check("rstmid_l3_busy", busy3, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mm1 = 0; mm3 = 0;
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 4'(i), 8'h00, 0);
    drive(0, 0, 0, 4'h0, 8'h00, 1);
    idle(3);
    check("post_rst_pass", pass1, 1);
    check("post_rst_err", err1, 0);
    check("post_rst_mm_pulses", mm1, 0);
    check("post_rst_l3_pass", pass3, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
